// File: rtl/hid_ps2_encoder_pkg.sv
// Shared types and constants for the HID boot-report to PS/2 Set-2 scancode encoder.
package hid_ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOD_REL,
        KEY_REL,
        MOD_PRS,
        KEY_PRS,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        EM_E0,
        EM_F0,
        EM_CODE
    } emit_e;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] HID_ROLLOVER = 8'h01;

    // Modifier bit index -> {ext, code}
    function automatic logic [8:0] mod_code(input logic [2:0] bit_idx);
        logic [8:0] r;
        case (bit_idx)
            3'd0:    r = {1'b0, 8'h14};
            3'd1:    r = {1'b0, 8'h12};
            3'd2:    r = {1'b0, 8'h11};
            3'd3:    r = {1'b1, 8'h1F};
            3'd4:    r = {1'b1, 8'h14};
            3'd5:    r = {1'b0, 8'h59};
            3'd6:    r = {1'b1, 8'h11};
            default: r = {1'b1, 8'h27};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hid_ps2_lut.sv
// Combinational ROM: HID usage (0x04..0x65) to PS/2 Set-2 make code.
module hid_ps2_lut (
    input  logic [7:0] usage_i,
    output logic       valid_o,
    output logic       ext_o,
    output logic [7:0] code_o
);

    // PrintScreen (0x46) and Pause (0x48) need multi-code sequences and are not encoded
    assign valid_o = (usage_i inside {[8'h04:8'h65]}) && (usage_i != 8'h46) && (usage_i != 8'h48);
    assign ext_o   = usage_i inside {[8'h49:8'h52], 8'h54, 8'h58, 8'h65};

    always_comb begin
        code_o = '0;
        case (usage_i)
            8'h04: code_o = 8'h1C; 8'h05: code_o = 8'h32; 8'h06: code_o = 8'h21; 8'h07: code_o = 8'h23;
            8'h08: code_o = 8'h24; 8'h09: code_o = 8'h2B; 8'h0A: code_o = 8'h34; 8'h0B: code_o = 8'h33;
            8'h0C: code_o = 8'h43; 8'h0D: code_o = 8'h3B; 8'h0E: code_o = 8'h42; 8'h0F: code_o = 8'h4B;
            8'h10: code_o = 8'h3A; 8'h11: code_o = 8'h31; 8'h12: code_o = 8'h44; 8'h13: code_o = 8'h4D;
            8'h14: code_o = 8'h15; 8'h15: code_o = 8'h2D; 8'h16: code_o = 8'h1B; 8'h17: code_o = 8'h2C;
            8'h18: code_o = 8'h3C; 8'h19: code_o = 8'h2A; 8'h1A: code_o = 8'h1D; 8'h1B: code_o = 8'h22;
            8'h1C: code_o = 8'h35; 8'h1D: code_o = 8'h1A; 8'h1E: code_o = 8'h16; 8'h1F: code_o = 8'h1E;
            8'h20: code_o = 8'h26; 8'h21: code_o = 8'h25; 8'h22: code_o = 8'h2E; 8'h23: code_o = 8'h36;
            8'h24: code_o = 8'h3D; 8'h25: code_o = 8'h3E; 8'h26: code_o = 8'h46; 8'h27: code_o = 8'h45;
            8'h28: code_o = 8'h5A; 8'h29: code_o = 8'h76; 8'h2A: code_o = 8'h66; 8'h2B: code_o = 8'h0D;
            8'h2C: code_o = 8'h29; 8'h2D: code_o = 8'h4E; 8'h2E: code_o = 8'h55; 8'h2F: code_o = 8'h54;
            8'h30: code_o = 8'h5B; 8'h31: code_o = 8'h5D; 8'h32: code_o = 8'h5D; 8'h33: code_o = 8'h4C;
            8'h34: code_o = 8'h52; 8'h35: code_o = 8'h0E; 8'h36: code_o = 8'h41; 8'h37: code_o = 8'h49;
            8'h38: code_o = 8'h4A; 8'h39: code_o = 8'h58; 8'h3A: code_o = 8'h05; 8'h3B: code_o = 8'h06;
            8'h3C: code_o = 8'h04; 8'h3D: code_o = 8'h0C; 8'h3E: code_o = 8'h03; 8'h3F: code_o = 8'h0B;
            8'h40: code_o = 8'h83; 8'h41: code_o = 8'h0A; 8'h42: code_o = 8'h01; 8'h43: code_o = 8'h09;
            8'h44: code_o = 8'h78; 8'h45: code_o = 8'h07; 8'h47: code_o = 8'h7E; 8'h49: code_o = 8'h70;
            8'h4A: code_o = 8'h6C; 8'h4B: code_o = 8'h7D; 8'h4C: code_o = 8'h71; 8'h4D: code_o = 8'h69;
            8'h4E: code_o = 8'h7A; 8'h4F: code_o = 8'h74; 8'h50: code_o = 8'h6B; 8'h51: code_o = 8'h72;
            8'h52: code_o = 8'h75; 8'h53: code_o = 8'h77; 8'h54: code_o = 8'h4A; 8'h55: code_o = 8'h7C;
            8'h56: code_o = 8'h7B; 8'h57: code_o = 8'h79; 8'h58: code_o = 8'h5A; 8'h59: code_o = 8'h69;
            8'h5A: code_o = 8'h72; 8'h5B: code_o = 8'h7A; 8'h5C: code_o = 8'h6B; 8'h5D: code_o = 8'h73;
            8'h5E: code_o = 8'h74; 8'h5F: code_o = 8'h6C; 8'h60: code_o = 8'h75; 8'h61: code_o = 8'h7D;
            8'h62: code_o = 8'h70; 8'h63: code_o = 8'h71; 8'h64: code_o = 8'h61; 8'h65: code_o = 8'h2F;
            default: code_o = '0;
        endcase
    end

endmodule

// File: rtl/hid_ps2_encoder.sv
// Diffs each HID boot-keyboard report against the last one and streams PS/2 Set-2
// break/make sequences one byte per strobe, honouring sc_ready and a minimum byte gap.
module hid_ps2_encoder
    import hid_ps2_pkg::*;
#(
    parameter int unsigned BYTE_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       report_upd,
    input  logic [7:0] kb_status,
    input  logic [7:0] kb_dat0,
    input  logic [7:0] kb_dat1,
    input  logic [7:0] kb_dat2,
    input  logic [7:0] kb_dat3,
    input  logic [7:0] kb_dat4,
    input  logic [7:0] kb_dat5,
    input  logic       sc_ready,
    output logic [7:0] kb_scancode,
    output logic       kb_scancode_upd,
    output logic       busy,
    output logic       overrun
);

    state_e          state_q, state_d;
    emit_e           em_q, em_d;
    logic            em_active_q, em_active_d, em_brk_q, em_brk_d;
    logic [7:0]      em_code_q, em_code_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      gap_q, gap_d;
    logic [7:0]      cur_mod_q, cur_mod_d, prev_mod_q, prev_mod_d, pend_mod_q, pend_mod_d;
    logic [5:0][7:0] cur_key_q, cur_key_d, prev_key_q, prev_key_d, pend_key_q, pend_key_d;
    logic            pend_valid_q, pend_valid_d, overrun_q, overrun_d;

    logic [5:0][7:0] in_key, ref_key, oth_key;
    logic [7:0]      sel_key, lut_code, cand_code;
    logic [8:0]      mod_ec;
    logic            lut_valid, lut_ext, dup_lower, in_other, rollover;
    logic            cand_hit, cand_ext, cand_brk, gap_ok;

    assign in_key  = {kb_dat5, kb_dat4, kb_dat3, kb_dat2, kb_dat1, kb_dat0};
    assign ref_key = (state_q == KEY_REL) ? prev_key_q : cur_key_q;
    assign oth_key = (state_q == KEY_REL) ? cur_key_q : prev_key_q;
    assign sel_key = ref_key[idx_q];
    assign mod_ec  = mod_code(idx_q);
    assign gap_ok  = gap_q >= 8'(BYTE_GAP);
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

    hid_ps2_lut u_lut (
        .usage_i (sel_key),
        .valid_o (lut_valid),
        .ext_o   (lut_ext),
        .code_o  (lut_code)
    );

    always_comb begin
        dup_lower = 1'b0;
        in_other  = 1'b0;
        rollover  = 1'b1;
        for (int unsigned j = 0; j < 6; j++) begin
            if ((3'(j) < idx_q) && (ref_key[j] == sel_key)) dup_lower = 1'b1;
            if (oth_key[j] == sel_key) in_other = 1'b1;
            if (cur_key_q[j] != HID_ROLLOVER) rollover = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;     em_d = em_q;               em_active_d = em_active_q;
        em_brk_d = em_brk_q;   em_code_d = em_code_q;     idx_d = idx_q;
        cur_mod_d = cur_mod_q; cur_key_d = cur_key_q;     prev_mod_d = prev_mod_q;
        prev_key_d = prev_key_q; pend_mod_d = pend_mod_q; pend_key_d = pend_key_q;
        pend_valid_d = pend_valid_q; overrun_d = overrun_q;
        gap_d = (gap_q == '1) ? gap_q : gap_q + 8'd1;
        cand_hit = 1'b0; cand_ext = 1'b0; cand_brk = 1'b0; cand_code = '0;
        kb_scancode_upd = 1'b0;
        kb_scancode = '0;

        if (report_upd && (state_q != IDLE)) begin
            pend_valid_d = 1'b1;
            pend_mod_d   = kb_status;
            pend_key_d   = in_key;
            if (pend_valid_q) overrun_d = 1'b1;
        end

        if (em_active_q) begin
            if (sc_ready && gap_ok) begin
                kb_scancode_upd = 1'b1;
                gap_d = 8'd1;
                case (em_q)
                    EM_E0: begin kb_scancode = PS2_EXT; em_d = em_brk_q ? EM_F0 : EM_CODE; end
                    EM_F0: begin kb_scancode = PS2_BRK; em_d = EM_CODE; end
                    default: begin kb_scancode = em_code_q; em_active_d = 1'b0; end
                endcase
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // A queued report is older than one arriving now, so it is scanned first
                    if (pend_valid_q) begin
                        cur_mod_d = pend_mod_q; cur_key_d = pend_key_q;
                        pend_valid_d = 1'b0; state_d = MOD_REL; idx_d = '0;
                        if (report_upd) begin
                            pend_valid_d = 1'b1; pend_mod_d = kb_status; pend_key_d = in_key;
                        end
                    end else if (report_upd) begin
                        cur_mod_d = kb_status; cur_key_d = in_key;
                        state_d = MOD_REL; idx_d = '0;
                    end
                end
                MOD_REL: begin
                    if (rollover) state_d = IDLE;
                    else begin
                        cand_hit = prev_mod_q[idx_q] & ~cur_mod_q[idx_q];
                        {cand_ext, cand_code} = mod_ec; cand_brk = 1'b1;
                        if (idx_q == 3'd7) begin state_d = KEY_REL; idx_d = '0; end
                        else idx_d = idx_q + 3'd1;
                    end
                end
                KEY_REL: begin
                    cand_hit = (sel_key != '0) && !dup_lower && !in_other && lut_valid;
                    cand_ext = lut_ext; cand_code = lut_code; cand_brk = 1'b1;
                    if (idx_q == 3'd5) begin state_d = MOD_PRS; idx_d = '0; end
                    else idx_d = idx_q + 3'd1;
                end
                MOD_PRS: begin
                    cand_hit = ~prev_mod_q[idx_q] & cur_mod_q[idx_q];
                    {cand_ext, cand_code} = mod_ec;
                    if (idx_q == 3'd7) begin state_d = KEY_PRS; idx_d = '0; end
                    else idx_d = idx_q + 3'd1;
                end
                KEY_PRS: begin
                    cand_hit = (sel_key != '0) && !dup_lower && !in_other && lut_valid;
                    cand_ext = lut_ext; cand_code = lut_code;
                    if (idx_q == 3'd5) begin state_d = COMMIT; idx_d = '0; end
                    else idx_d = idx_q + 3'd1;
                end
                COMMIT: begin
                    prev_mod_d = cur_mod_q; prev_key_d = cur_key_q; state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (cand_hit) begin
                em_active_d = 1'b1; em_brk_d = cand_brk; em_code_d = cand_code;
                em_d = cand_ext ? EM_E0 : (cand_brk ? EM_F0 : EM_CODE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;      em_q <= EM_E0;         em_active_q <= 1'b0;
            em_brk_q <= 1'b0;     em_code_q <= '0;       idx_q <= '0;
            gap_q <= '1;          cur_mod_q <= '0;       cur_key_q <= '0;
            prev_mod_q <= '0;     prev_key_q <= '0;      pend_mod_q <= '0;
            pend_key_q <= '0;     pend_valid_q <= 1'b0;  overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;   em_q <= em_d;          em_active_q <= em_active_d;
            em_brk_q <= em_brk_d; em_code_q <= em_code_d; idx_q <= idx_d;
            gap_q <= gap_d;       cur_mod_q <= cur_mod_d; cur_key_q <= cur_key_d;
            prev_mod_q <= prev_mod_d; prev_key_q <= prev_key_d; pend_mod_q <= pend_mod_d;
            pend_key_q <= pend_key_d; pend_valid_q <= pend_valid_d; overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/hid_ps2_encoder.md
Name: hid_ps2_encoder

Overview:
Converts USB HID boot-keyboard reports (modifier byte plus six keycode slots) from the MCU link into a serial stream of PS/2 Set-2 scancodes. Each new report is diffed against the last accepted report, and the block emits break and make sequences for every change. Output bytes are strobed one at a time on kb_scancode/kb_scancode_upd, using the same port names as the usb_ps2_keybuf scancode input, so the block is the writer into that buffer. A ready input lets the consumer apply backpressure.

Parameters:
BYTE_GAP, 4, minimum number of clk cycles from one kb_scancode_upd strobe to the next (range 1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
report_upd  in  1  one-cycle strobe; kb_status/kb_dat0..5 hold a new report
kb_status  in  8  HID modifier bits: 0 LCtrl, 1 LShift, 2 LAlt, 3 LGUI, 4 RCtrl, 5 RShift, 6 RAlt, 7 RGUI
kb_dat0..kb_dat5  in  8 each  HID keycode slots; 0x00 means empty
sc_ready  in  1  consumer can accept a byte this cycle
kb_scancode  out  8  scancode byte; valid while kb_scancode_upd=1
kb_scancode_upd  out  1  one-cycle strobe per byte
busy  out  1  high whenever the state is not IDLE
overrun  out  1  sticky; set when a pending report is overwritten; cleared only by reset

Behaviour:
- Reset (asynchronous, takes effect mid-sequence too):
  - kb_scancode=0, kb_scancode_upd=0, busy=0, overrun=0, state=IDLE.
  - Stored previous report is cleared to all-zero (all keys released) and the pending flag is cleared.
  - No partial sequence is completed after reset is released.
- Report capture:
  - In IDLE, report_upd copies the inputs into cur; the scan starts on the next cycle.
  - report_upd while busy: the report is stored in the pending register. A later report_upd before that pending report is consumed overwrites it and sets overrun.
  - On return to IDLE with pending set, the pending report is loaded and the scan starts on the next cycle.
- Rollover: a report whose six slots all equal 0x01 is discarded. prev is unchanged, nothing is emitted, and the block returns to IDLE after one cycle.
- Scan states (fixed order, one candidate examined per cycle):
  - MOD_REL: modifier bits 0..7 that are set in prev and clear in cur.
  - KEY_REL: prev slots 0..5 that are non-zero and absent from every cur slot.
  - MOD_PRS: modifier bits 0..7 that are clear in prev and set in cur.
  - KEY_PRS: cur slots 0..5 that are non-zero and absent from prev.
  - COMMIT: prev <= cur, then go to IDLE.
- Candidate filtering:
  - A slot whose keycode equals a lower-numbered slot of the same report is skipped, so a duplicate produces only one sequence.
  - A keycode for which the LUT reports valid=0 is skipped.
  - A skipped or unchanged candidate costs exactly 1 cycle.
- Emission sub-FSM:
  - Byte order is E0 (only if ext), then F0 (only for a break), then code.
  - A byte goes out only in a cycle where sc_ready=1 and at least BYTE_GAP cycles have passed since the previous strobe.
  - kb_scancode_upd is high for exactly that one cycle. When sc_ready=0 the sub-FSM stalls indefinitely and emits nothing.
  - The scan resumes on the cycle after the last byte of the sequence.
- Modifier codes: LCtrl 14, LShift 12, LAlt 11, LGUI E0 1F, RCtrl E0 14, RShift 59, RAlt E0 11, RGUI E0 27.
- Gap counter: 8-bit, saturating. It is preset to saturated at reset, so the first byte after reset is not delayed.

Decomposition:
- Shared package hid_ps2_pkg holds:
  - state enum {IDLE, MOD_REL, KEY_REL, MOD_PRS, KEY_PRS, COMMIT};
  - emit sub-state enum {EM_E0, EM_F0, EM_CODE};
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, HID_ROLLOVER=8'h01;
  - the modifier code table.
- One sub-module, hid_ps2_lut: purely combinational ROM mapping a HID usage (8 bits) to {valid, ext, code[7:0]}.
  - Covers usages 0x04..0x65.
  - Sample entries: 0x04 to 1C, 0x28 to 5A, 0x29 to 76, 0x2C to 29, 0x3A to 05, 0x52 to E0 75, 0x50 to E0 6B.
  - Pause and PrintScreen return valid=0.

Test Plan:
- From reset, sc_ready=1: report {00,04,00..} -> exactly one strobe, byte 1C; busy returns to 0; a second identical report emits nothing.
- Continuing from that state, report {00,00..} -> strobes F0, 1C in order, spaced at least 4 cycles apart.
- Report {02,52,00..} -> strobes 12, E0, 75. Then report {00,00..} -> F0 12, then E0 F0 75; releases of modifiers come before keys.
- Hold sc_ready=0 for 50 cycles during a sequence -> no strobes during the hold; after sc_ready rises, the remaining bytes arrive unchanged and in order.
- Send three reports while busy -> only the third is applied after the current scan; overrun=1. A rollover report {00,01,01,01,01,01,01} -> no strobes and prev unchanged.
- Assert reset during an E0-F0-code break sequence -> outputs go to 0 immediately. After release, report {00,04,..} -> byte 1C only.
